seq_addsub_16b: RTL and testbench
=================================

Name: seq_addsub_16b

Overview:
- Multi-cycle 16-bit adder/subtractor built around a single 4-bit ripple-carry slice that is reused once per clock.
- Processes operands LSB-slice first, with the carry held in a register between slices.
- Serves as the sequential, subtract-capable counterpart to the combinational 4-bit adder; it is the area-cheap arithmetic unit for datapaths that can tolerate latency.
- Start/busy/done handshake to the surrounding control logic.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock; the slice count is NSL = WIDTH/SLICE.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse; result valid
- S  output  WIDTH  result
- C_out  output  1  carry out of MSB; for sub, 1 = no borrow
- Ofl  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, S=0, C_out=0, Ofl=0. All internal operand, carry and slice-counter registers are cleared.
- IDLE:
  - On start=1 at a rising edge: latch A into opA, latch B^{WIDTH{sub}} into opB, set carry=sub, set slice counter=0.
  - Go to CALC; busy rises in the next cycle.
- CALC (one slice per cycle):
  - sum = opA[slice] + opB[slice] + carry, where slice is SLICE bits selected by the counter.
  - Write the SLICE-bit sum into S[slice], update carry, increment the counter.
  - On the final slice (counter = NSL-1): C_out = final carry; Ofl = (msbA_eff == msbB_eff) && (S_msb != msbA_eff), using the latched operands. Go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then return to IDLE.
- Latency: done is high in the cycle following edge NSL+1 after the start edge (4 CALC edges + 1 for the default configuration). start-to-done = NSL+1 cycles.
- Output holding:
  - S, C_out and Ofl hold their values from done until the next accepted start.
  - S is updated slice-by-slice during CALC and is not valid until done.
- start while busy=1: ignored; no queueing; operands are not re-latched.
- start held high continuously: a new operation is accepted in each IDLE cycle, i.e. every NSL+2 cycles.
- A, B and sub may change freely after the start edge.
- rst_n asserted mid-operation: the block returns immediately to reset values; no done pulse; the partial result is discarded.
- Arithmetic is modulo 2^WIDTH.

Optional Feature:
- Macro ADDSUB_SAT_EN.
- Defined: when Ofl=1 in the final slice, S is forced to the signed saturation value in the DONE cycle. Positive overflow gives 0x7FFF; negative overflow gives 0x8000, generalised to WIDTH. Ofl is still reported as 1; C_out is unchanged.
- Undefined: S is the wrapped modulo result. Saturation logic is absent.

Test Plan:
- Add: A=0x1234, B=0x4321, sub=0 -> S=0x5555, C_out=0, Ofl=0; done exactly 5 cycles after the start edge; busy high for 5 cycles.
- Unsigned wrap: A=0xFFFF, B=0x0001, sub=0 -> S=0x0000, C_out=1, Ofl=0. Subtract with borrow: A=0x0000, B=0x0001, sub=1 -> S=0xFFFF, C_out=0, Ofl=0.
- Signed overflow:
  - A=0x7FFF, B=0x0001, add -> Ofl=1; S=0x8000, or 0x7FFF with ADDSUB_SAT_EN.
  - A=0x8000, B=0x0001, sub -> Ofl=1; S=0x7FFF, or 0x8000 with ADDSUB_SAT_EN.
- Handshake: pulse start with A=0x0001, B=0x0002. Then re-pulse start with A=0xAAAA in CALC cycle 2 -> result S=0x0003 and only one done pulse. S must remain 0x0003 for 10 idle cycles.
- Reset mid-op: assert rst_n=0 in CALC cycle 2 -> busy, done, S, C_out and Ofl are all 0 immediately. After release, a new A=0x00FF, B=0x0001 add gives S=0x0100.
- Random: 1000 back-to-back operations with random A, B and sub, compared at done against a model {C_out,S}=A+(sub?~B:B)+sub. Flag mismatches with an "ERRORCHECK" message.

Source files
------------

// File: rtl/seq_addsub_16b_if.sv
// ---------------------------------------------------------------------------
// seq_addsub_16b_if
//   Request/result bundle for the sequential adder/subtractor.
//
//   Signals (direction seen from the arithmetic unit, i.e. the slave side):
//     start  in   request, only accepted while the unit is idle
//     sub    in   0 = A+B, 1 = A-B, captured together with start
//     A, B   in   WIDTH-bit operands, captured together with start
//     busy   out  unit is working (CALC or DONE)
//     done   out  one-cycle pulse, result valid
//     S      out  WIDTH-bit result
//     C_out  out  carry out of the MSB (for subtraction 1 = no borrow)
//     Ofl    out  two's-complement signed overflow
//
//   Modports:
//     master  surrounding control logic (drives the request)
//     slave   the arithmetic unit (drives the result)
// ---------------------------------------------------------------------------
interface seq_addsub_16b_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             Ofl;

  modport master (
    output start, sub, A, B,
    input  busy, done, S, C_out, Ofl
  );

  modport slave (
    input  start, sub, A, B,
    output busy, done, S, C_out, Ofl
  );

endinterface : seq_addsub_16b_if

// File: rtl/seq_addsub_16b.sv
// ---------------------------------------------------------------------------
// seq_addsub_16b
//   Multi-cycle WIDTH-bit adder/subtractor built from one SLICE-bit ripple
//   carry slice that is reused once per clock, LSB slice first. The carry
//   between slices lives in a register. Subtraction is done as
//   A + ~B + 1 by inverting B on capture and seeding the carry with 1.
//
//   Timing (default WIDTH=16, SLICE=4, NSL=4):
//     start edge        : IDLE -> CALC, operands captured
//     NSL CALC edges    : one slice each, last one -> DONE
//     DONE cycle        : done=1, busy=1, then back to IDLE
//   so a new request can be accepted every NSL+2 cycles.
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of seq_addsub_16b_if (start/sub/A/B in,
//            busy/done/S/C_out/Ofl out)
//
//   Parameters:
//     WIDTH  operand/result width, must be a multiple of SLICE and must match
//            the WIDTH of the connected interface
//     SLICE  bits processed per clock
//
//   Optional build macro:
//     ADDSUB_SAT_EN  when defined, a signed overflow forces S to the signed
//                    saturation value (0x7FF..F positive, 0x80..0 negative)
//                    for the DONE cycle onward; Ofl and C_out are unchanged.
//                    When undefined, S is the wrapped modulo result.
// ---------------------------------------------------------------------------
module seq_addsub_16b #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_addsub_16b_if.slave    bus
);

  localparam int NSL   = WIDTH / SLICE;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CNT_W-1:0] LAST_SL = CNT_W'(NSL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q,   opa_d;    // operand A as captured
  logic [WIDTH-1:0] opb_q,   opb_d;    // operand B, already inverted for sub
  logic             carry_q, carry_d;  // carry between slices
  logic [CNT_W-1:0] cnt_q,   cnt_d;    // index of the slice being processed
  logic [WIDTH-1:0] s_q,     s_d;
  logic             c_out_q, c_out_d;
  logic             ofl_q,   ofl_d;

  // -------------------------------------------------------------------------
  // The single ripple-carry slice
  // -------------------------------------------------------------------------
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE:0]   slice_sum;
  logic             ofl_w;

  assign slice_a   = opa_q[int'(cnt_q)*SLICE +: SLICE];
  assign slice_b   = opb_q[int'(cnt_q)*SLICE +: SLICE];
  assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_q};

  // Only meaningful on the last slice, where slice_sum[SLICE-1] is the MSB of
  // the full result. Both operand MSBs are the effective ones (B inverted for
  // subtraction), so the same rule covers add and subtract.
  assign ofl_w = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                 (slice_sum[SLICE-1] != opa_q[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
  // Overflow sign follows the operands: two positives overflow upward.
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ofl_d   = ofl_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          opa_d   = bus.A;
          opb_d   = bus.B ^ {WIDTH{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        s_d[int'(cnt_q)*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        carry_d = slice_sum[SLICE];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_SL) begin
          c_out_d = slice_sum[SLICE];
          ofl_d   = ofl_w;
`ifdef ADDSUB_SAT_EN
          if (ofl_w) begin
            s_d = opa_q[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
`endif
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: the operand, carry and counter registers are reset along with the
  // outputs so that a reset mid-operation leaves no stale partial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ofl_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed from the previous state, independent of order.
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ofl_q   <= ofl_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy  = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.S     = s_q;
  assign bus.C_out = c_out_q;
  assign bus.Ofl   = ofl_q;

endmodule : seq_addsub_16b

// File: tb/tb_seq_addsub_16b.sv
// ---------------------------------------------------------------------------
// tb_seq_addsub_16b
//   Self-checking bench for seq_addsub_16b (WIDTH=16, SLICE=4).
//   Directed vector table, hand-written handshake / reset / back-to-back
//   sequences, and a block of random operations against a reference model.
//   Expected values follow the ADDSUB_SAT_EN setting of the build.
// ---------------------------------------------------------------------------
module tb_seq_addsub_16b;

  localparam int WIDTH = 16;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  seq_addsub_16b_if #(.WIDTH(WIDTH)) bus ();

  seq_addsub_16b #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] exp_s;
    logic        exp_c;
    logic        exp_o;
  } vec_t;

  // Waits until idle, issues one request, scrambles the inputs after the
  // start edge, and collects the result on the done pulse. done_cyc is the
  // cycle index (1 = first cycle after the start edge) of the first done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s_in,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int done_cyc, output int busy_cyc, output int done_hi);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.A     = a;
    bus.B     = b;
    bus.sub   = s_in;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.B     = 16'($urandom);
    bus.sub   = 1'($urandom);
    rs = '0; rc = 1'b0; ro = 1'b0;
    done_cyc = 0; busy_cyc = 0; done_hi = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_hi++;
        if (done_cyc == 0) begin
          done_cyc = k;
          rs = bus.S;
          rc = bus.C_out;
          ro = bus.Ofl;
        end
      end
      if (!bus.busy) break;
    end
  endtask

  vec_t        vecs[11];
  logic [15:0] rs;
  logic        rc, ro;
  int          dcyc, bcyc, dhi;

  initial begin
    // ---------------- directed vector table ----------------
    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{16'h5555, 16'hAAAA, 1'b1, SAT ? 16'h7FFF : 16'hAAAB, 1'b0, 1'b1};
    vecs[7]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0};
    vecs[10] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1};

    // ---------------- reset state ----------------
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("reset busy",  32'(bus.busy),  32'd0);
    check("reset done",  32'(bus.done),  32'd0);
    check("reset S",     32'(bus.S),     32'd0);
    check("reset C_out", 32'(bus.C_out), 32'd0);
    check("reset Ofl",   32'(bus.Ofl),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, rs, rc, ro, dcyc, bcyc, dhi);
      check($sformatf("vec%0d S", i),       32'(rs), 32'(vecs[i].exp_s));
      check($sformatf("vec%0d C_out", i),   32'(rc), 32'(vecs[i].exp_c));
      check($sformatf("vec%0d Ofl", i),     32'(ro), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d done cycle", i), 32'(dcyc), 32'd5);
      check($sformatf("vec%0d busy cycles", i), 32'(bcyc), 32'd5);
      check($sformatf("vec%0d done width", i), 32'(dhi), 32'd1);
    end

    // ---------------- start while busy is ignored ----------------
    begin
      int done_cnt;
      int bad;
      logic [15:0] s_seen;
      @(negedge clk);
      bus.A = 16'h0001; bus.B = 16'h0002; bus.sub = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;                 // now in CALC cycle 2
      bus.A = 16'hAAAA; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      done_cnt = 0;
      s_seen   = '0;
      for (int k = 0; k < 15; k++) begin
        @(negedge clk);
        if (bus.done) begin
          done_cnt++;
          s_seen = bus.S;
        end
      end
      check("hs done count", 32'(done_cnt), 32'd1);
      check("hs S",          32'(s_seen),   32'h0003);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus.S !== 16'h0003 || bus.busy !== 1'b0) bad++;
      end
      check("hs S hold idle cycles bad", 32'(bad), 32'd0);
    end

    // ---------------- start held high: one op every 6 cycles ----------------
    begin
      int first, second, n;
      first = -1; second = -1; n = 0;
      @(negedge clk);
      bus.A = 16'h0001; bus.B = 16'h0001; bus.sub = 1'b0; bus.start = 1'b1;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (bus.done) begin
          n++;
          if (first < 0) first = k;
          else if (second < 0) second = k;
        end
      end
      bus.start = 1'b0;
      check("b2b done spacing", 32'(second - first), 32'd6);
      check("b2b S", 32'(bus.S), 32'h0002);
      repeat (8) @(negedge clk);
    end

    // ---------------- reset mid-operation ----------------
    run_op(16'h8000, 16'h8000, 1'b0, rs, rc, ro, dcyc, bcyc, dhi);
    check("pre-reset C_out", 32'(rc), 32'd1);
    @(negedge clk);
    bus.A = 16'h1234; bus.B = 16'h4321; bus.sub = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;                   // inside CALC cycle 2
    rst_n = 1'b0;
    #1;
    check("midrst busy",  32'(bus.busy),  32'd0);
    check("midrst done",  32'(bus.done),  32'd0);
    check("midrst S",     32'(bus.S),     32'd0);
    check("midrst C_out", 32'(bus.C_out), 32'd0);
    check("midrst Ofl",   32'(bus.Ofl),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, dcyc, bcyc, dhi);
    check("post-reset S",    32'(rs),   32'h0100);
    check("post-reset done", 32'(dcyc), 32'd5);

    // ---------------- random operations vs. model ----------------
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b, bm, es;
      logic        s_in, eo;
      logic [16:0] full;
      int          sa, sb, r;
      a    = 16'($urandom);
      b    = 16'($urandom);
      s_in = 1'($urandom);
      bm   = s_in ? ~b : b;
      full = {1'b0, a} + {1'b0, bm} + 17'(s_in);
      sa   = int'($signed(a));
      sb   = int'($signed(b));
      r    = s_in ? (sa - sb) : (sa + sb);
      eo   = (r > 32767) || (r < -32768);
      es   = full[15:0];
      if (SAT && eo) es = (r > 0) ? 16'h7FFF : 16'h8000;
      run_op(a, b, s_in, rs, rc, ro, dcyc, bcyc, dhi);
      check($sformatf("ERRORCHECK op%0d a=%h b=%h sub=%0d {done_cyc,C,O,S}", i, a, b, s_in),
            {8'(dcyc), 6'd0, rc, ro, rs}, {8'd5, 6'd0, full[16], eo, es});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seq_addsub_16b
